// File: rtl/controller_sequencer.sv
// controller_sequencer
//   SAP-1 control unit: six-state one-hot ring counter (T1..T6) plus an
//   opcode decoder producing the 12-bit control word each cycle.
//
//   Build option: define SAP1_HLT_EN to enable the HLT opcode (4'hF).
//   Without it, 4'hF decodes as NOP, hlt stays 0 and the ring never freezes.
//
//   Ports:
//     clk      in   system clock, rising-edge active
//     clr      in   asynchronous active-high reset
//     opcode   in   [3:0] instruction register bits [7:4], used in T4..T6
//     Cp Ep Lm Ce Li Ei La Ea Su Eu Lb Lo
//              out  active-high control word
//     hlt      out  halted flag
//     t_state  out  [5:0] one-hot ring state, bit 0 = T1 .. bit 5 = T6
module controller_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       Ce,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic       hlt,
    output logic [5:0] t_state
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_e;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    ring_e state_q, state_d;
    logic  hlt_q, hlt_d;
    logic  halt_op;

    always_comb begin
`ifdef SAP1_HLT_EN
        halt_op = (opcode == OP_HLT);
`else
        halt_op = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= T1;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hlt_q   <= hlt_d;
        end
    end

    // Next state: ring advances each edge unless halted; HLT parks in T4.
    always_comb begin
        state_d = state_q;
        hlt_d   = hlt_q;
        if (!hlt_q) begin
            case (state_q)
                T1:      state_d = T2;
                T2:      state_d = T3;
                T3:      state_d = T4;
                T4: begin
                    if (halt_op) hlt_d = 1'b1;
                    else         state_d = T5;
                end
                T5:      state_d = T6;
                T6:      state_d = T1;
                default: state_d = T1;
            endcase
        end
    end

    // Control word decode. Gated by clr so outputs drop asynchronously
    // with reset even though the ring already sits in T1.
    always_comb begin
        Cp = 1'b0; Ep = 1'b0; Lm = 1'b0; Ce = 1'b0;
        Li = 1'b0; Ei = 1'b0; La = 1'b0; Ea = 1'b0;
        Su = 1'b0; Eu = 1'b0; Lb = 1'b0; Lo = 1'b0;
        if (!clr && !hlt_q) begin
            case (state_q)
                T1: begin Ep = 1'b1; Lm = 1'b1; end
                T2: begin Cp = 1'b1; end
                T3: begin Ce = 1'b1; Li = 1'b1; end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin Ei = 1'b1; Lm = 1'b1; end
                        OP_OUT:                 begin Ea = 1'b1; Lo = 1'b1; end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         begin Ce = 1'b1; La = 1'b1; end
                        OP_ADD, OP_SUB: begin Ce = 1'b1; Lb = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD: begin Eu = 1'b1; La = 1'b1; end
                        OP_SUB: begin Eu = 1'b1; Su = 1'b1; La = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign t_state = state_q;
    assign hlt     = hlt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
module tb_controller_sequencer;

    logic       clk, clr;
    logic [3:0] opcode;
    logic       Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo, hlt;
    logic [5:0] t_state;

    controller_sequencer dut (
        .clk(clk), .clr(clr), .opcode(opcode),
        .Cp(Cp), .Ep(Ep), .Lm(Lm), .Ce(Ce), .Li(Li), .Ei(Ei),
        .La(La), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo),
        .hlt(hlt), .t_state(t_state)
    );

`ifdef SAP1_HLT_EN
    localparam bit HLT_EN = 1'b1;
`else
    localparam bit HLT_EN = 1'b0;
`endif

    // Control word bit masks, order {Cp,Ep,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
    localparam logic [11:0] M_CP = 12'h800, M_EP = 12'h400, M_LM = 12'h200,
                            M_CE = 12'h100, M_LI = 12'h080, M_EI = 12'h040,
                            M_LA = 12'h020, M_EA = 12'h010, M_SU = 12'h008,
                            M_EU = 12'h004, M_LB = 12'h002, M_LO = 12'h001;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state: instruction step 0..5 (T1..T6) and halted flag
    int unsigned phase  = 0;
    bit          halted = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_word();
        return {Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo};
    endfunction

    // Expected control word straight from the instruction table
    function automatic logic [11:0] exp_word(input int unsigned ph, input logic [3:0] op,
                                             input bit hl, input bit in_clr);
        if (in_clr || hl) return '0;
        case (ph)
            0: return M_EP | M_LM;
            1: return M_CP;
            2: return M_CE | M_LI;
            3: if (op == 4'h0 || op == 4'h1 || op == 4'h2) return M_EI | M_LM;
               else if (op == 4'hE) return M_EA | M_LO;
               else return '0;
            4: if (op == 4'h0) return M_CE | M_LA;
               else if (op == 4'h1 || op == 4'h2) return M_CE | M_LB;
               else return '0;
            5: if (op == 4'h1) return M_EU | M_LA;
               else if (op == 4'h2) return M_EU | M_SU | M_LA;
               else return '0;
            default: return '0;
        endcase
    endfunction

    task automatic compare_all(input string tag);
        logic [11:0] w;
        w = dut_word();
        check_eq({tag, ".t_state"}, 32'(t_state), 32'(1) << phase);
        check_eq({tag, ".hlt"}, 32'(hlt), 32'(halted));
        check_eq({tag, ".word"}, 32'(w), 32'(exp_word(phase, opcode, halted, clr)));
        check_eq({tag, ".su_without_eu"}, 32'(Su & ~Eu), 32'd0);
        check_eq({tag, ".one_bus_driver"}, 32'($countones({Ep, Ce, Ei, Ea, Eu}) <= 1), 32'd1);
    endtask

    // One clock cycle: drive opcode, check mid-cycle, step the model at the edge
    task automatic run_cycle(input logic [3:0] op, input string tag);
        opcode = op;
        #2;
        compare_all(tag);
        @(posedge clk);
        if (!halted) begin
            if (HLT_EN && phase == 3 && op == 4'hF) halted = 1'b1;
            else phase = (phase + 1) % 6;
        end
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        repeat (6) run_cycle(op, tag);
    endtask

    initial begin
        clr    = 1'b1;
        opcode = 4'h1;

        // Reset held for three cycles
        repeat (3) begin
            @(posedge clk);
            #3;
            compare_all("reset");
            check_eq("reset.word_zero", 32'(dut_word()), 32'd0);
        end
        clr = 1'b0;
        #1;
        check_eq("release.ep_lm", 32'({Ep, Lm}), 32'b11);
        check_eq("release.word", 32'(dut_word()), 32'(M_EP | M_LM));

        run_instr(4'h0, "lda");
        run_instr(4'h1, "add");
        run_instr(4'h2, "sub");
        run_instr(4'h7, "nop7");
        check_eq("nop7.back_to_t1", 32'(t_state), 32'h1);
        run_instr(4'hE, "out");

        for (int unsigned i = 0; i < 40; i++) begin
            logic [3:0] op;
            case ($urandom_range(0, 5))
                0: op = 4'h0;
                1: op = 4'h1;
                2: op = 4'h2;
                3: op = 4'hE;
                default: op = 4'($urandom_range(0, 15));
            endcase
            if (HLT_EN && op == 4'hF) op = 4'h3;
            run_instr(op, "rand");
        end

        // Asynchronous clear in T5 of ADD
        repeat (4) run_cycle(4'h1, "midrst");
        #1;
        check_eq("midrst.t5_word", 32'(dut_word()), 32'(M_CE | M_LB));
        clr = 1'b1;
        #1;
        check_eq("midrst.word_zero", 32'(dut_word()), 32'd0);
        check_eq("midrst.t_state", 32'(t_state), 32'h1);
        check_eq("midrst.hlt", 32'(hlt), 32'd0);
        #1;
        clr    = 1'b0;
        phase  = 0;
        halted = 1'b0;
        run_instr(4'h2, "post_rst");

        // HLT opcode: halts when enabled, otherwise behaves as NOP
        run_instr(4'hF, "hlt_op");
        repeat (20) run_cycle(4'hF, "halted");
        if (HLT_EN) begin
            check_eq("halted.t_state", 32'(t_state), 32'h8);
            check_eq("halted.hlt", 32'(hlt), 32'd1);
        end else begin
            check_eq("nohlt.hlt", 32'(hlt), 32'd0);
        end
        clr = 1'b1;
        #1;
        check_eq("hlt_clr.t_state", 32'(t_state), 32'h1);
        check_eq("hlt_clr.hlt", 32'(hlt), 32'd0);
        check_eq("hlt_clr.word", 32'(dut_word()), 32'd0);
        #1;
        clr    = 1'b0;
        phase  = 0;
        halted = 1'b0;
        run_instr(4'h1, "after_hlt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
